// File: rtl/ecc_26_rd_pipe_pkg.sv
// Shared SECDED constants, skid-buffer state encoding and the H-matrix
// column generator for the 26-bit read-side ECC stage.
package ecc_26_rd_pipe_pkg;

    localparam int ECC_DATA_WIDTH   = 26;
    localparam int ECC_PARITY_WIDTH = 6;

    // Two-entry output skid buffer occupancy
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // One decoded word as it travels through the skid buffer
    typedef struct packed {
        logic [ECC_DATA_WIDTH-1:0] data;
        logic                      sbit;
        logic                      dbit;
    } ecc_word_t;

    // Hsiao-style column for data bit idx: the idx-th odd-weight (3 or 5)
    // 6-bit value in ascending order. There are exactly 26 of them, so every
    // data bit gets a distinct odd column, every double error yields an
    // even-weight syndrome that matches neither a data nor a parity column.
    function automatic logic [ECC_PARITY_WIDTH-1:0] secded_col(input int idx);
        logic [ECC_PARITY_WIDTH-1:0] col;
        int n;
        int w;
        col = '0;
        n   = 0;
        for (int v = 1; v < (2 ** ECC_PARITY_WIDTH); v++) begin
            w = $countones(v[ECC_PARITY_WIDTH-1:0]);
            if (w == 3 || w == 5) begin
                if (n == idx) begin
                    col = v[ECC_PARITY_WIDTH-1:0];
                end
                n = n + 1;
            end
        end
        return col;
    endfunction

endpackage

// File: rtl/ecc_26_cal.sv
// Combinational SECDED check/correct for one 26-bit data word.
module ecc_26_cal
    import ecc_26_rd_pipe_pkg::*;
(
    input  logic [ECC_DATA_WIDTH-1:0]   data,
    input  logic [ECC_PARITY_WIDTH-1:0] parity,
    input  logic                        bypass,
    output logic [ECC_DATA_WIDTH-1:0]   data_fix,
    output logic                        sbit_err,
    output logic                        dbit_err
);

    logic [ECC_PARITY_WIDTH-1:0] term [ECC_DATA_WIDTH];
    logic [ECC_DATA_WIDTH-1:0]   flip;
    logic [ECC_PARITY_WIDTH-1:0] calc_parity;
    logic [ECC_PARITY_WIDTH-1:0] syndrome;
    logic                        data_hit;
    logic                        parity_hit;

    // Per-bit parity contribution and syndrome-to-column match
    generate
        for (genvar gi = 0; gi < ECC_DATA_WIDTH; gi++) begin : g_col
            localparam logic [ECC_PARITY_WIDTH-1:0] COL = secded_col(gi);
            assign term[gi] = data[gi] ? COL : '0;
            assign flip[gi] = (syndrome == COL);
        end
    endgenerate

    // Recompute parity from data and compare with the stored parity
    always_comb begin
        calc_parity = '0;
        for (int i = 0; i < ECC_DATA_WIDTH; i++) begin
            calc_parity = calc_parity ^ term[i];
        end
    end

    assign syndrome   = calc_parity ^ parity;
    assign data_hit   = |flip;
    assign parity_hit = $onehot(syndrome);

    // Classify the syndrome and apply the single-bit correction
    always_comb begin
        data_fix = data;
        sbit_err = 1'b0;
        dbit_err = 1'b0;
        if (!bypass) begin
            data_fix = data ^ flip;
            sbit_err = data_hit | parity_hit;
            dbit_err = (syndrome != '0) & ~data_hit & ~parity_hit;
        end
    end

endmodule

// File: rtl/ecc_26_rd_pipe.sv
// Read-side ECC stage: SECDED decode on input, 2-entry skid buffer on the
// output, saturating error counters and first-error address capture.
module ecc_26_rd_pipe
    import ecc_26_rd_pipe_pkg::*;
#(
    parameter int DATA_WIDTH   = ECC_DATA_WIDTH,
    parameter int PARITY_WIDTH = ECC_PARITY_WIDTH,
    parameter int ADDR_WIDTH   = 5,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [PARITY_WIDTH-1:0] in_parity,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic                    bypass,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_sbit_err,
    output logic                    out_dbit_err,
    input  logic                    clr_stat,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic                    err_addr_vld
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    skid_state_e state_reg, state_next;
    ecc_word_t   head_reg, tail_reg, dec_word;
    logic        accept;
    logic        load_head_in, load_head_tail, load_tail;

    logic [CNT_WIDTH-1:0]  sbit_cnt_reg, sbit_cnt_next;
    logic [CNT_WIDTH-1:0]  dbit_cnt_reg, dbit_cnt_next;
    logic [ADDR_WIDTH-1:0] err_addr_reg, err_addr_next;
    logic                  err_vld_reg, err_vld_next;
    logic                  cap_dbit_reg, cap_dbit_next;
    logic                  sbit_ev, dbit_ev;

    ecc_26_cal u_cal (
        .data     (in_data),
        .parity   (in_parity),
        .bypass   (bypass),
        .data_fix (dec_word.data),
        .sbit_err (dec_word.sbit),
        .dbit_err (dec_word.dbit)
    );

    // in_ready comes straight from the state register, never from out_ready
    assign in_ready  = (state_reg != SKID_TWO);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_reg != SKID_EMPTY);
    assign out_data     = head_reg.data;
    assign out_sbit_err = head_reg.sbit;
    assign out_dbit_err = head_reg.dbit;

    // Skid buffer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SKID_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Skid buffer next state and entry load selects
    always_comb begin
        state_next     = state_reg;
        load_head_in   = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        case (state_reg)
            SKID_EMPTY: begin
                if (accept) begin
                    load_head_in = 1'b1;
                    state_next   = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && out_ready) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
                    load_tail  = 1'b1;
                    state_next = SKID_TWO;
                end else if (out_ready) begin
                    state_next = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (out_ready) begin
                    load_head_tail = 1'b1;
                    state_next     = SKID_ONE;
                end
            end
            default: state_next = SKID_EMPTY;
        endcase
    end

    // Head (output) and tail entries; head holds while valid and stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            if (load_head_in) begin
                head_reg <= dec_word;
            end else if (load_head_tail) begin
                head_reg <= tail_reg;
            end
            if (load_tail) begin
                tail_reg <= dec_word;
            end
        end
    end

    assign sbit_ev = accept & dec_word.sbit;
    assign dbit_ev = accept & dec_word.dbit;

    // Statistics: clear first, then record this cycle's accepted event
    always_comb begin
        sbit_cnt_next = clr_stat ? '0 : sbit_cnt_reg;
        dbit_cnt_next = clr_stat ? '0 : dbit_cnt_reg;
        err_vld_next  = clr_stat ? 1'b0 : err_vld_reg;
        cap_dbit_next = clr_stat ? 1'b0 : cap_dbit_reg;
        err_addr_next = err_addr_reg;
        if (sbit_ev && sbit_cnt_next != CNT_MAX) begin
            sbit_cnt_next = sbit_cnt_next + 1'b1;
        end
        if (dbit_ev && dbit_cnt_next != CNT_MAX) begin
            dbit_cnt_next = dbit_cnt_next + 1'b1;
        end
        if (!err_vld_next && (sbit_ev || dbit_ev)) begin
            err_addr_next = in_addr;
            err_vld_next  = 1'b1;
            cap_dbit_next = dbit_ev;
        end else if (err_vld_next && !cap_dbit_next && dbit_ev) begin
            // Upgrade an sbit-only capture to the first uncorrectable word
            err_addr_next = in_addr;
            cap_dbit_next = 1'b1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbit_cnt_reg <= '0;
            dbit_cnt_reg <= '0;
            err_addr_reg <= '0;
            err_vld_reg  <= 1'b0;
            cap_dbit_reg <= 1'b0;
        end else begin
            sbit_cnt_reg <= sbit_cnt_next;
            dbit_cnt_reg <= dbit_cnt_next;
            err_addr_reg <= err_addr_next;
            err_vld_reg  <= err_vld_next;
            cap_dbit_reg <= cap_dbit_next;
        end
    end

    assign sbit_cnt     = sbit_cnt_reg;
    assign dbit_cnt     = dbit_cnt_reg;
    assign err_addr     = err_addr_reg;
    assign err_addr_vld = err_vld_reg;

endmodule

// File: tb/tb_ecc_26_rd_pipe.sv
// Directed bench for ecc_26_rd_pipe (counters built 2 bits wide so that
// saturation is reachable in a handful of words).
module tb_ecc_26_rd_pipe;

    localparam int DW = 26;
    localparam int PW = 6;
    localparam int AW = 5;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [PW-1:0] in_parity;
    logic [AW-1:0] in_addr;
    logic          bypass;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sbit_err;
    logic          out_dbit_err;
    logic          clr_stat;
    logic [CW-1:0] sbit_cnt;
    logic [CW-1:0] dbit_cnt;
    logic [AW-1:0] err_addr;
    logic          err_addr_vld;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ecc_26_rd_pipe #(
        .DATA_WIDTH   (DW),
        .PARITY_WIDTH (PW),
        .ADDR_WIDTH   (AW),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_parity    (in_parity),
        .in_addr      (in_addr),
        .bypass       (bypass),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sbit_err (out_sbit_err),
        .out_dbit_err (out_dbit_err),
        .clr_stat     (clr_stat),
        .sbit_cnt     (sbit_cnt),
        .dbit_cnt     (dbit_cnt),
        .err_addr     (err_addr),
        .err_addr_vld (err_addr_vld)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [PW-1:0] p,
                         input logic [AW-1:0] a);
        in_valid  = v;
        in_data   = d;
        in_parity = p;
        in_addr   = a;
        if (v) $display("txn: data=%07h parity=%02h addr=%0d bypass=%0b out_ready=%0b clr=%0b",
                        d, p, a, bypass, out_ready, clr_stat);
    endtask

    initial begin
        rst       = 1'b1;
        bypass    = 1'b0;
        out_ready = 1'b1;
        clr_stat  = 1'b0;
        drive(1'b0, '0, '0, '0);
        repeat (2) tick();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_flags", 32'({out_sbit_err, out_dbit_err}), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_sbit_cnt", 32'(sbit_cnt), 0);
        chk("rst_dbit_cnt", 32'(dbit_cnt), 0);
        chk("rst_err_addr", 32'(err_addr), 0);
        chk("rst_err_vld", 32'(err_addr_vld), 0);
        rst = 1'b0;
        tick();
        chk("idle_out_valid", 32'(out_valid), 0);

        // Clean stream: one output per cycle, 1-cycle latency
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 26'h0, 6'h00, AW'(i));
            tick();
            chk("clean_valid", 32'(out_valid), 1);
            chk("clean_data", 32'(out_data), 0);
            chk("clean_flags", 32'({out_sbit_err, out_dbit_err}), 0);
            chk("clean_in_ready", 32'(in_ready), 1);
        end
        drive(1'b0, '0, '0, '0);
        tick();
        chk("clean_drain", 32'(out_valid), 0);
        chk("clean_sbit_cnt", 32'(sbit_cnt), 0);
        chk("clean_dbit_cnt", 32'(dbit_cnt), 0);
        chk("clean_err_vld", 32'(err_addr_vld), 0);

        // Single-bit data error at addr 3
        drive(1'b1, 26'h0000001, 6'h00, 5'd3);
        tick();
        chk("sbit_data", 32'(out_data), 0);
        chk("sbit_flag", 32'({out_sbit_err, out_dbit_err}), 32'h2);
        chk("sbit_cnt1", 32'(sbit_cnt), 1);
        chk("sbit_addr", 32'(err_addr), 3);
        chk("sbit_vld", 32'(err_addr_vld), 1);

        // Double-bit error overrides the sbit capture once
        drive(1'b1, 26'h0000003, 6'h00, 5'd9);
        tick();
        chk("dbit_flag", 32'({out_sbit_err, out_dbit_err}), 32'h1);
        chk("dbit_data", 32'(out_data), 32'h3);
        chk("dbit_cnt1", 32'(dbit_cnt), 1);
        chk("dbit_addr", 32'(err_addr), 9);
        chk("dbit_sbit_cnt", 32'(sbit_cnt), 1);
        drive(1'b1, 26'h0000003, 6'h00, 5'd12);
        tick();
        chk("dbit2_cnt", 32'(dbit_cnt), 2);
        chk("dbit2_addr_kept", 32'(err_addr), 9);
        drive(1'b0, '0, '0, '0);
        tick();
        chk("dbit_drain", 32'(out_valid), 0);

        // Backpressure with valid codewords 0/00, 1/07, 2/0B, 4/0D
        out_ready = 1'b0;
        drive(1'b1, 26'h0, 6'h00, 5'd1);
        tick();
        chk("bp_w0_valid", 32'(out_valid), 1);
        chk("bp_w0_data", 32'(out_data), 0);
        chk("bp_ready_one", 32'(in_ready), 1);
        drive(1'b1, 26'h1, 6'h07, 5'd2);
        tick();
        chk("bp_ready_two", 32'(in_ready), 0);
        chk("bp_hold1", 32'(out_data), 0);
        drive(1'b1, 26'h2, 6'h0B, 5'd4);
        tick();
        chk("bp_ready_stall", 32'(in_ready), 0);
        chk("bp_hold2", 32'(out_data), 0);
        chk("bp_hold_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        chk("bp_w1_data", 32'(out_data), 1);
        chk("bp_ready_back", 32'(in_ready), 1);
        chk("bp_w1_flags", 32'({out_sbit_err, out_dbit_err}), 0);
        tick();
        chk("bp_w2_data", 32'(out_data), 2);
        drive(1'b1, 26'h4, 6'h0D, 5'd5);
        tick();
        chk("bp_w3_data", 32'(out_data), 4);
        chk("bp_w3_flags", 32'({out_sbit_err, out_dbit_err}), 0);
        chk("bp_sbit_cnt", 32'(sbit_cnt), 1);
        chk("bp_dbit_cnt", 32'(dbit_cnt), 2);
        drive(1'b0, '0, '0, '0);
        tick();
        chk("bp_drain", 32'(out_valid), 0);

        // Clear, then saturate the 2-bit sbit counter
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        chk("clr_sbit_cnt", 32'(sbit_cnt), 0);
        chk("clr_dbit_cnt", 32'(dbit_cnt), 0);
        chk("clr_vld", 32'(err_addr_vld), 0);
        for (int i = 0; i < 5; i++) begin
            int exp_cnt;
            exp_cnt = (i < 3) ? i + 1 : 3;
            drive(1'b1, 26'h0000004, 6'h00, AW'(16 + i));
            tick();
            chk("sat_data", 32'(out_data), 0);
            chk("sat_flag", 32'(out_sbit_err), 1);
            chk("sat_cnt", 32'(sbit_cnt), 32'(exp_cnt));
            chk("sat_addr", 32'(err_addr), 16);
        end

        // Clear coincident with an sbit word: clear first, then record
        clr_stat = 1'b1;
        drive(1'b1, 26'h0000002, 6'h00, 5'd7);
        tick();
        clr_stat = 1'b0;
        chk("clrev_sbit_cnt", 32'(sbit_cnt), 1);
        chk("clrev_dbit_cnt", 32'(dbit_cnt), 0);
        chk("clrev_addr", 32'(err_addr), 7);
        chk("clrev_vld", 32'(err_addr_vld), 1);
        chk("clrev_data", 32'(out_data), 0);

        // Parity-bit error: data kept, sbit set, capture not overwritten
        drive(1'b1, 26'h0, 6'h01, 5'd8);
        tick();
        chk("perr_data", 32'(out_data), 0);
        chk("perr_flags", 32'({out_sbit_err, out_dbit_err}), 32'h2);
        chk("perr_cnt", 32'(sbit_cnt), 2);
        chk("perr_addr", 32'(err_addr), 7);

        // Bypass: raw data through, no flags, stats frozen
        bypass = 1'b1;
        drive(1'b1, 26'h0000001, 6'h00, 5'd30);
        tick();
        chk("byp_data", 32'(out_data), 1);
        chk("byp_flags", 32'({out_sbit_err, out_dbit_err}), 0);
        chk("byp_sbit_cnt", 32'(sbit_cnt), 2);
        chk("byp_dbit_cnt", 32'(dbit_cnt), 0);
        chk("byp_addr", 32'(err_addr), 7);
        bypass = 1'b0;
        drive(1'b0, '0, '0, '0);
        tick();

        // Asynchronous reset with two words buffered
        out_ready = 1'b0;
        drive(1'b1, 26'h1, 6'h07, 5'd1);
        tick();
        drive(1'b1, 26'h2, 6'h0B, 5'd2);
        tick();
        chk("rst2_full", 32'(in_ready), 0);
        drive(1'b0, '0, '0, '0);
        rst = 1'b1;
        #1;
        chk("rst2_out_valid", 32'(out_valid), 0);
        chk("rst2_in_ready", 32'(in_ready), 1);
        chk("rst2_out_data", 32'(out_data), 0);
        chk("rst2_sbit_cnt", 32'(sbit_cnt), 0);
        chk("rst2_err_vld", 32'(err_addr_vld), 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("rst2_after", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
